// File: rtl/sha1_w_schedule.sv
// SHA-1 message-schedule generator.
// Loads one 512-bit block as 16 sequential words into a 16-deep shift window,
// then streams W0..W79 from the oldest window slot while feeding
// rotl1(r13^r8^r2^r0) into the newest slot. Each output word carries its round index.
module sha1_w_schedule #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_data,
  output logic [6:0]        w_index,
  output logic              w_last,
  output logic              busy
);

  localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

  typedef enum logic {
    S_LOAD,
    S_EMIT
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        load_cnt_q, load_cnt_d;
  logic [6:0]        idx_q, idx_d;
  logic [WORD_W-1:0] r_q    [16];
  logic [WORD_W-1:0] r_next [16];
  logic              shift_en;
  logic [WORD_W-1:0] shift_in;
  logic [WORD_W-1:0] mix;
  logic [WORD_W-1:0] feedback;

  // Recurrence term: W[t+16] = rotl1(W[t+13] ^ W[t+8] ^ W[t+2] ^ W[t]).
  assign mix      = r_q[13] ^ r_q[8] ^ r_q[2] ^ r_q[0];
  assign feedback = {mix[WORD_W-2:0], mix[WORD_W-1]};

  // Next-state logic: load handshakes, emit handshakes, clear overrides both.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    idx_d      = idx_q;
    shift_en   = 1'b0;
    shift_in   = in_word;
    if (clear) begin
      state_d    = S_LOAD;
      load_cnt_d = 4'd0;
      idx_d      = 7'd0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid) begin
            shift_en = 1'b1;
            shift_in = in_word;
            if (load_cnt_q == 4'd15) begin
              state_d    = S_EMIT;
              load_cnt_d = 4'd0;
              idx_d      = 7'd0;
            end else begin
              load_cnt_d = load_cnt_q + 4'd1;
            end
          end
        end
        S_EMIT: begin
          if (w_ready) begin
            shift_en = 1'b1;
            shift_in = feedback;
            if (idx_q == LAST_IDX) begin
              // Words computed past the final round are left in the window
              // and simply shifted out by the next block's 16 loads.
              state_d = S_LOAD;
              idx_d   = 7'd0;
            end else begin
              idx_d = idx_q + 7'd1;
            end
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  // Control registers: state, load counter and round index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      load_cnt_q <= 4'd0;
      idx_q      <= 7'd0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      idx_q      <= idx_d;
    end
  end

  // Window: each slot takes its younger neighbour; the newest slot takes shift_in.
  for (genvar gi = 0; gi < 16; gi++) begin : g_window
    if (gi < 15) begin : g_mid
      assign r_next[gi] = r_q[gi+1];
    end else begin : g_top
      assign r_next[gi] = shift_in;
    end

    // Window slot register; cleared on reset or abort, shifts on any handshake.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q[gi] <= '0;
      end else if (clear) begin
        r_q[gi] <= '0;
      end else if (shift_en) begin
        r_q[gi] <= r_next[gi];
      end
    end
  end

  assign in_ready = (state_q == S_LOAD);
  assign w_valid  = (state_q == S_EMIT);
  assign w_data   = r_q[0];
  assign w_index  = idx_q;
  assign w_last   = w_valid && (idx_q == LAST_IDX);
  assign busy     = !((state_q == S_LOAD) && (load_cnt_q == 4'd0));

endmodule

// File: tb/tb_sha1_w_schedule.sv
// Self-checking bench for sha1_w_schedule: "abc" block vectors, back-pressure,
// input gaps, clear mid-block, back-to-back blocks and asynchronous reset mid-block.
module tb_sha1_w_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [6:0]  w_index;
  logic        w_last;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] blk  [16];
  logic [31:0] expw [80];
  logic [31:0] got  [80];
  logic [31:0] got1 [80];

  typedef struct {
    int          idx;
    logic [31:0] w;
  } vec_t;
  vec_t vec [8];

  sha1_w_schedule #(.WORD_W(32), .ROUNDS(80)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .w_index  (w_index),
    .w_last   (w_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference schedule in the textbook form W[t] = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]).
  task automatic model();
    logic [31:0] x;
    for (int t = 0; t < 16; t++) expw[t] = blk[t];
    for (int t = 16; t < 80; t++) begin
      x = expw[t-3] ^ expw[t-8] ^ expw[t-14] ^ expw[t-16];
      expw[t] = {x[30:0], x[31]};
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask

  // Called at a negedge; drives word 0 in the same cycle. gap>0 inserts idle cycles.
  task automatic load_block(input int gap);
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < gap * (i % 3); g++) begin
        in_valid = 1'b0;
        chk("no_early_valid_gap", 32'(w_valid), 32'd0);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_word  = blk[i];
      chk("load_ready", 32'(in_ready), 32'd1);
      chk("no_early_valid", 32'(w_valid), 32'd0);
      if (i == 1) chk("busy_loading", 32'(busy), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("first_valid_latency", 32'(w_valid), 32'd1);
    chk("first_index", 32'(w_index), 32'd0);
  endtask

  // Called at a negedge in EMIT. Stops early (before the handshake) when n==stop_at.
  task automatic collect(input int stall_pct, input bit junk_in, input int stop_at, input string tag);
    int          n;
    int          cyc;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic [6:0]  prev_idx;
    n = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0; prev_idx = '0;
    while (n < 80 && cyc < 3000) begin
      if (n == stop_at) break;
      chk("valid_high", 32'(w_valid), 32'd1);
      if (prev_stall) begin
        chk("stall_data_stable", w_data, prev_data);
        chk("stall_index_stable", 32'(w_index), 32'(prev_idx));
      end
      w_ready = (stall_pct == 0) || ($urandom_range(99) >= 32'(stall_pct));
      if (junk_in) begin
        in_valid = 1'b1;
        in_word  = $urandom;
        chk("ready_low_in_emit", 32'(in_ready), 32'd0);
      end
      if (w_ready) begin
        got[n] = w_data;
        chk("index", 32'(w_index), 32'(n));
        chk("last", 32'(w_last), 32'(n == 79));
        n++;
      end
      prev_stall = !w_ready;
      prev_data  = w_data;
      prev_idx   = w_index;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (stop_at >= 80) begin
      w_ready = 1'b0;
      chk("word_count", 32'(n), 32'd80);
      chk("ready_after_block", 32'(in_ready), 32'd1);
      chk("valid_after_block", 32'(w_valid), 32'd0);
      chk("busy_after_block", 32'(busy), 32'd0);
      chk("last_after_block", 32'(w_last), 32'd0);
      $display("block %s words=%0d cycles=%0d", tag, n, cyc);
    end else begin
      chk("stop_reached", 32'(n), 32'(stop_at));
      $display("block %s stopped at index %0d", tag, n);
    end
  endtask

  task automatic compare_all(input string tag);
    for (int t = 0; t < 80; t++)
      chk($sformatf("%s_W%0d", tag, t), got[t], expw[t]);
  endtask

  initial begin
    vec[0] = '{0,  32'h61626380};
    vec[1] = '{1,  32'h00000000};
    vec[2] = '{14, 32'h00000000};
    vec[3] = '{15, 32'h00000018};
    vec[4] = '{16, 32'hC2C4C700};
    vec[5] = '{17, 32'h00000000};
    vec[6] = '{18, 32'h00000030};
    vec[7] = '{19, 32'h85898E01};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_word = '0; w_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_w_valid", 32'(w_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_w_valid", 32'(w_valid), 32'd0);
    chk("post_rst_w_last", 32'(w_last), 32'd0);
    chk("post_rst_w_data", w_data, 32'd0);
    chk("post_rst_w_index", 32'(w_index), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // "abc" block, no stalls, no gaps.
    set_abc(); model();
    load_block(0);
    collect(0, 1'b0, 80, "abc");
    for (int v = 0; v < 8; v++)
      chk($sformatf("abc_vec_W%0d", vec[v].idx), got[vec[v].idx], vec[v].w);
    compare_all("abc");
    for (int t = 0; t < 80; t++) got1[t] = got[t];

    // Same block with random back-pressure and junk on in_valid during EMIT.
    load_block(0);
    collect(40, 1'b1, 80, "abc_stall");
    for (int t = 0; t < 80; t++) chk($sformatf("stall_vs_free_W%0d", t), got[t], got1[t]);
    for (int v = 0; v < 8; v++)
      chk($sformatf("stall_vec_W%0d", vec[v].idx), got[vec[v].idx], vec[v].w);

    // Input gaps during LOAD.
    load_block(2);
    collect(0, 1'b0, 80, "abc_gaps");
    compare_all("gaps");

    // clear at index 37 together with w_ready.
    load_block(0);
    collect(0, 1'b0, 37, "abc_clear");
    chk("clear_at_index", 32'(w_index), 32'd37);
    clear = 1'b1; w_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0; w_ready = 1'b0;
    chk("clear_in_ready", 32'(in_ready), 32'd1);
    chk("clear_w_valid", 32'(w_valid), 32'd0);
    chk("clear_w_index", 32'(w_index), 32'd0);
    chk("clear_busy", 32'(busy), 32'd0);
    chk("clear_w_data", w_data, 32'd0);
    set_random(); model();
    load_block(0);
    collect(0, 1'b0, 80, "after_clear");
    compare_all("after_clear");

    // Back-to-back: next block loaded in the cycle right after the final handshake.
    set_random(); model();
    load_block(0);
    collect(0, 1'b0, 80, "b2b");
    compare_all("b2b");

    // Asynchronous reset in the middle of EMIT.
    set_abc(); model();
    load_block(0);
    collect(0, 1'b0, 10, "abc_reset");
    rst_n = 1'b0;
    #1;
    chk("async_rst_w_valid", 32'(w_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_w_index", 32'(w_index), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; w_ready = 1'b0;
    @(negedge clk);
    chk("rel_rst_in_ready", 32'(in_ready), 32'd1);
    chk("rel_rst_w_valid", 32'(w_valid), 32'd0);
    chk("rel_rst_w_index", 32'(w_index), 32'd0);
    chk("rel_rst_busy", 32'(busy), 32'd0);
    load_block(0);
    collect(0, 1'b0, 80, "after_reset");
    compare_all("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha1_w_schedule.md
Name: sha1_w_schedule

Overview:
- SHA-1 message-schedule generator. It accepts one 512-bit block as 16 sequential 32-bit words and emits the 80 schedule words W0..W79 in order, each tagged with its round index.
- It sits between the padding/block-formatting stage and the round datapath.
- The round datapath advances its 0..79 round counter on each accepted word, and this block tracks the same index.

Parameters:
- WORD_W, 32, schedule word width. Fixed by SHA-1; only 32 is supported.
- ROUNDS, 80, number of words emitted per block. The final index is ROUNDS-1.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- clear, input, 1: synchronous abort. Returns the block to LOAD and discards the current block.
- in_valid, input, 1: message word valid.
- in_ready, output, 1: block can accept a message word.
- in_word, input, 32: message word, big-endian W0 first.
- w_valid, output, 1: schedule word valid.
- w_ready, input, 1: round datapath accepts the word.
- w_data, output, 32: schedule word W[w_index].
- w_index, output, 7: round index, 0..79.
- w_last, output, 1: high with w_valid when w_index==79.
- busy, output, 1: high in every state except LOAD with load_cnt==0.

Behaviour:
- Reset and clear values: state=LOAD, load_cnt=0, w_index=0, window registers r[0..15]=0.
  - Outputs after reset or clear: in_ready=1, w_valid=0, w_last=0, w_data=0, busy=0.
- Storage: 16x32 shift window r[0..15]. r[0] is the oldest word. w_data is driven combinationally from r[0].
- State LOAD:
  - in_ready=1 and w_valid=0.
  - On in_valid&&in_ready: shift the window left (r[i]<=r[i+1]), set r[15]<=in_word, and increment load_cnt.
  - On the 16th accepted word (load_cnt==15), go to EMIT with w_index=0 and load_cnt=0.
  - The first w_valid appears the cycle after the 16th input handshake, so latency is 1 cycle.
- State EMIT:
  - in_ready=0 and w_valid=1.
  - w_data=r[0], w_index=current index, w_last=(w_index==79).
  - On w_valid&&w_ready: shift the window left and set r[15]<=rotl1(r[13]^r[8]^r[2]^r[0]).
    - This yields W[t+16]=rotl1(W[t+13]^W[t+8]^W[t+2]^W[t]), so W16..W79 come out of r[0] in order without special-casing t<16.
    - w_index increments on the same handshake.
  - On the handshake at w_index==79: go to LOAD and set w_index<=0. Words computed beyond W79 are ignored. in_ready=1 on the next cycle.
- Back-pressure: while w_ready=0, w_data, w_index and w_last hold stable and w_valid stays high. Outputs never change without a handshake.
- Wrap: w_index never exceeds 79. The 7-bit compare with 79 is exact. XOR and rotate are modulo 2^32, with no carries.
- Simultaneous events:
  - clear has priority over every handshake in the same cycle. Neither an in_word nor a w_data handshake takes effect on a clear cycle.
  - rst_n asserted mid-block discards all state immediately and asynchronously. Outputs take their reset values while rst_n is low.
- in_valid is ignored in EMIT; no word is consumed and no overlap is allowed. w_ready is ignored in LOAD.
- busy=1 from the first accepted input word until the handshake at w_index==79 completes.

Test Plan:
- Reset: hold rst_n=0 mid-EMIT, then release -> in_ready=1, w_valid=0, w_index=0, busy=0 on the first edge after release.
- "abc" block: load W0=0x61626380, W1..W14=0, W15=0x00000018 with w_ready=1. Require:
  - W0=0x61626380 at the first w_valid, 1 cycle after the 16th input.
  - W16=0xC2C4C700, W17=0x00000000, W18=0x00000030, W19=0x85898E01.
  - Exactly 80 words, w_last only at index 79, in_ready=1 on the following cycle.
- Back-pressure: randomly deassert w_ready during the "abc" block -> identical W sequence. w_data and w_index stay stable during every stall cycle.
- Input gaps: insert idle cycles on in_valid during LOAD -> same output as the gap-free run. No w_valid before the 16th input handshake.
- clear: assert clear at w_index=37 together with w_ready=1 -> no increment occurs, state returns to LOAD, and a fresh block then starts at index 0 with correct words.
- Back-to-back blocks: load block B immediately after block A's index-79 handshake -> B's W0..W79 match a software SHA-1 model, with no corruption from A's window contents.
